// File: rtl/router_out_arbiter_if.sv
// Bundle of the arbiter's flit and status signals for one router output port.
// slave is the arbiter's view; master is the upstream/downstream environment's view.
interface router_out_arbiter_if #(
  parameter int NUM_IN = 5,
  parameter int FLIT_W = 34
);
  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [NUM_IN*FLIT_W-1:0] in_flit;
  logic [NUM_IN-1:0]        in_req;
  logic [NUM_IN-1:0]        in_ack;
  logic [FLIT_W-1:0]        out_flit;
  logic                     out_req;
  logic                     out_ack;
  logic [IDX_W-1:0]         owner;
  logic                     locked;
  logic                     proto_err;

  modport master (
    output in_flit, in_req, out_ack,
    input  in_ack, out_flit, out_req, owner, locked, proto_err
  );

  modport slave (
    input  in_flit, in_req, out_ack,
    output in_ack, out_flit, out_req, owner, locked, proto_err
  );
endinterface

// File: rtl/router_out_arbiter.sv
// Round-robin wormhole arbiter for one mesh-router output port: locks the channel
// from head to tail flit and holds the outgoing flit in a req/ack output register.
module router_out_arbiter #(
  parameter int NUM_IN = 5,
  parameter int FLIT_W = 34,
  localparam int IDX_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
  input logic                 clk,
  input logic                 rst,
  router_out_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    FT_BODY   = 2'b00,
    FT_TAIL   = 2'b01,
    FT_HEAD   = 2'b10,
    FT_SINGLE = 2'b11
  } flit_type_e;

  typedef enum logic {IDLE, LOCKED} state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  owner_q, owner_d;
  logic [IDX_W-1:0]  rr_q, rr_d;
  logic              err_q, err_d;
  logic [FLIT_W-1:0] flit_q, flit_d;
  logic              req_q, req_d;

  logic [NUM_IN-1:0] ack;
  logic [NUM_IN-1:0] eligible;
  logic [NUM_IN-1:0] misframed;
  logic [IDX_W-1:0]  win;
  logic              found;
  logic              load_en;
  logic [FLIT_W-1:0] win_flit;
  logic [FLIT_W-1:0] owner_flit;
  flit_type_e        win_type;
  flit_type_e        owner_type;
  int                rr_idx;

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    return (int'(i) == NUM_IN - 1) ? '0 : i + 1'b1;
  endfunction

  assign load_en    = !req_q || bus.out_ack;
  assign win_flit   = bus.in_flit[int'(win)*FLIT_W +: FLIT_W];
  assign owner_flit = bus.in_flit[int'(owner_q)*FLIT_W +: FLIT_W];
  assign win_type   = flit_type_e'(win_flit[FLIT_W-1 -: 2]);
  assign owner_type = flit_type_e'(owner_flit[FLIT_W-1 -: 2]);

  // Type bit [FLIT_W-1] is set exactly for packet-opening flits (head, single).
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      eligible[i]  = bus.in_req[i] &&  bus.in_flit[i*FLIT_W + FLIT_W - 1];
      misframed[i] = bus.in_req[i] && !bus.in_flit[i*FLIT_W + FLIT_W - 1];
    end
  end

  always_comb begin
    found  = 1'b0;
    win    = '0;
    rr_idx = 0;
    for (int k = 0; k < NUM_IN; k++) begin
      rr_idx = int'(rr_q) + k;
      if (rr_idx >= NUM_IN) rr_idx = rr_idx - NUM_IN;
      if (!found && eligible[rr_idx]) begin
        found = 1'b1;
        win   = IDX_W'(rr_idx);
      end
    end
  end

  always_comb begin
    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    err_d   = err_q;
    flit_d  = flit_q;
    req_d   = req_q;
    ack     = '0;

    if (req_q && bus.out_ack) req_d = 1'b0;

    case (state_q)
      IDLE: begin
        if (|misframed) err_d = 1'b1;
        if (load_en && found) begin
          ack[win] = 1'b1;
          flit_d   = win_flit;
          req_d    = 1'b1;
          rr_d     = next_idx(win);
          if (win_type == FT_HEAD) begin
            state_d = LOCKED;
            owner_d = win;
          end
        end
      end
      LOCKED: begin
        if (load_en && bus.in_req[owner_q]) begin
          if (owner_type == FT_HEAD || owner_type == FT_SINGLE) begin
            err_d = 1'b1;
          end else begin
            ack[owner_q] = 1'b1;
            flit_d       = owner_flit;
            req_d        = 1'b1;
            if (owner_type == FT_TAIL) begin
              state_d = IDLE;
              owner_d = '0;
              rr_d    = next_idx(owner_q);
            end
          end
        end
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      owner_q <= '0;
      rr_q    <= '0;
      err_q   <= 1'b0;
      flit_q  <= '0;
      req_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      err_q   <= err_d;
      flit_q  <= flit_d;
      req_q   <= req_d;
    end
  end

  // Upstream must never see a consume while reset is held.
  assign bus.in_ack    = rst ? ack : '0;
  assign bus.out_flit  = flit_q;
  assign bus.out_req   = req_q;
  assign bus.owner     = owner_q;
  assign bus.locked    = (state_q == LOCKED);
  assign bus.proto_err = err_q;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed bench for router_out_arbiter: single flits, wormhole locking, fairness,
// backpressure, framing errors and asynchronous reset, with hand-computed expectations.
module tb_router_out_arbiter;

  localparam int NUM_IN = 5;
  localparam int FLIT_W = 34;

  localparam logic [1:0] HEAD   = 2'b10;
  localparam logic [1:0] BODY   = 2'b00;
  localparam logic [1:0] TAIL   = 2'b01;
  localparam logic [1:0] SINGLE = 2'b11;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  router_out_arbiter_if #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W)) bus ();

  router_out_arbiter #(.NUM_IN(NUM_IN), .FLIT_W(FLIT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input int i, input logic [1:0] t, input logic [31:0] p, input logic r);
    bus.in_flit[i*FLIT_W +: FLIT_W] = {t, p};
    bus.in_req[i] = r;
  endtask

  task automatic clear_all();
    bus.in_flit = '0;
    bus.in_req  = '0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bus.out_ack = 1'b0;
    for (int i = 0; i < NUM_IN; i++) set_in(i, SINGLE, 32'hEE, 1'b1);

    // Held in reset, with every input requesting.
    #12;
    check("rst_in_ack",    64'(bus.in_ack),    64'h0);
    check("rst_out_req",   64'(bus.out_req),   64'h0);
    check("rst_out_flit",  64'(bus.out_flit),  64'h0);
    check("rst_locked",    64'(bus.locked),    64'h0);
    check("rst_owner",     64'(bus.owner),     64'h0);
    check("rst_proto_err", 64'(bus.proto_err), 64'h0);
    clear_all();
    rst = 1'b1;
    tick();

    // Single flit from input 0.
    bus.out_ack = 1'b1;
    set_in(0, SINGLE, 32'h0000_00AA, 1'b1);
    #1;
    check("t1_in_ack", 64'(bus.in_ack), 64'h01);
    tick();
    check("t1_out_flit", 64'(bus.out_flit), 64'h3_0000_00AA);
    check("t1_out_req",  64'(bus.out_req),  64'h1);
    check("t1_locked",   64'(bus.locked),   64'h0);

    // rr_ptr is now 1: inputs 0 and 1 both offer, 1 must win.
    set_in(0, SINGLE, 32'h0000_000B, 1'b1);
    set_in(1, SINGLE, 32'h0000_001B, 1'b1);
    #1;
    check("t1_rr_in_ack", 64'(bus.in_ack), 64'h02);
    tick();
    check("t1_rr_out_flit", 64'(bus.out_flit), 64'h3_0000_001B);

    // Drain with nothing offered: out_req falls, out_flit holds.
    clear_all();
    #1;
    check("drain_in_ack", 64'(bus.in_ack), 64'h0);
    tick();
    check("drain_out_req",  64'(bus.out_req),  64'h0);
    check("drain_out_flit", 64'(bus.out_flit), 64'h3_0000_001B);

    // Input 4 single: moves rr_ptr from 2 back to 0.
    set_in(4, SINGLE, 32'h0000_004A, 1'b1);
    #1;
    check("wrap_in_ack", 64'(bus.in_ack), 64'h10);
    tick();
    check("wrap_out_flit", 64'(bus.out_flit), 64'h3_0000_004A);
    clear_all();

    // Packets from inputs 1 and 3; 1 holds the channel through its tail.
    set_in(1, HEAD, 32'h1000_0001, 1'b1);
    set_in(3, HEAD, 32'h3000_0001, 1'b1);
    #1;
    check("p1_head_ack", 64'(bus.in_ack), 64'h02);
    tick();
    check("p1_head_out", 64'(bus.out_flit), 64'h2_1000_0001);
    check("p1_locked",   64'(bus.locked),   64'h1);
    check("p1_owner",    64'(bus.owner),    64'h1);
    set_in(1, BODY, 32'h1000_0002, 1'b1);
    #1;
    check("p1_body_ack", 64'(bus.in_ack), 64'h02);
    tick();
    check("p1_body_out", 64'(bus.out_flit), 64'h0_1000_0002);
    check("p1_body_req", 64'(bus.out_req),  64'h1);
    set_in(1, TAIL, 32'h1000_0003, 1'b1);
    #1;
    check("p1_tail_ack", 64'(bus.in_ack), 64'h02);
    tick();
    check("p1_tail_out",  64'(bus.out_flit), 64'h1_1000_0003);
    check("p1_unlocked",  64'(bus.locked),   64'h0);
    check("p1_owner_clr", 64'(bus.owner),    64'h0);
    set_in(1, BODY, 32'h0, 1'b0);
    #1;
    check("p3_head_ack", 64'(bus.in_ack), 64'h08);
    tick();
    check("p3_head_out", 64'(bus.out_flit), 64'h2_3000_0001);
    check("p3_owner",    64'(bus.owner),    64'h3);
    set_in(3, BODY, 32'h3000_0002, 1'b1);
    #1;
    check("p3_body_ack", 64'(bus.in_ack), 64'h08);
    tick();
    check("p3_body_out", 64'(bus.out_flit), 64'h0_3000_0002);
    set_in(3, TAIL, 32'h3000_0003, 1'b1);
    #1;
    check("p3_tail_ack", 64'(bus.in_ack), 64'h08);
    tick();
    check("p3_tail_out", 64'(bus.out_flit), 64'h1_3000_0003);
    check("p3_unlocked", 64'(bus.locked),   64'h0);
    clear_all();

    // rr_ptr is 4: inputs 0 and 4 offer, 4 must win (leaves rr_ptr at 0).
    set_in(0, SINGLE, 32'h0000_000C, 1'b1);
    set_in(4, SINGLE, 32'h0000_004C, 1'b1);
    #1;
    check("rr4_in_ack", 64'(bus.in_ack), 64'h10);
    tick();
    check("rr4_out_flit", 64'(bus.out_flit), 64'h3_0000_004C);
    clear_all();

    // Fairness: all inputs offer singles; order 0,1,2,3,4,0 at one per cycle.
    for (int i = 0; i < NUM_IN; i++) set_in(i, SINGLE, 32'h50 + 32'(i), 1'b1);
    for (int k = 0; k < 6; k++) begin
      int g;
      g = k % NUM_IN;
      #1;
      check($sformatf("fair%0d_in_ack", k), 64'(bus.in_ack), 64'(1) << g);
      tick();
      check($sformatf("fair%0d_out_flit", k), 64'(bus.out_flit), {30'h0, SINGLE, 32'h50 + 32'(g)});
      check($sformatf("fair%0d_out_req", k),  64'(bus.out_req),  64'h1);
    end
    clear_all();

    // Backpressure mid-packet on input 2 (rr_ptr is 1).
    set_in(2, HEAD, 32'h2000_0001, 1'b1);
    #1;
    check("bp_head_ack", 64'(bus.in_ack), 64'h04);
    tick();
    check("bp_head_out", 64'(bus.out_flit), 64'h2_2000_0001);
    check("bp_owner",    64'(bus.owner),    64'h2);
    set_in(2, BODY, 32'h2000_0002, 1'b1);
    set_in(0, HEAD, 32'h0000_0F0F, 1'b1);
    bus.out_ack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      #1;
      check($sformatf("bp_stall%0d_in_ack", k), 64'(bus.in_ack), 64'h0);
      tick();
      check($sformatf("bp_stall%0d_out_flit", k), 64'(bus.out_flit), 64'h2_2000_0001);
      check($sformatf("bp_stall%0d_owner", k),    64'(bus.owner),    64'h2);
      check($sformatf("bp_stall%0d_out_req", k),  64'(bus.out_req),  64'h1);
    end
    bus.out_ack = 1'b1;
    #1;
    check("bp_body1_ack", 64'(bus.in_ack), 64'h04);
    tick();
    check("bp_body1_out", 64'(bus.out_flit), 64'h0_2000_0002);
    set_in(2, BODY, 32'h2000_0003, 1'b1);
    #1;
    check("bp_body2_ack", 64'(bus.in_ack), 64'h04);
    tick();
    check("bp_body2_out", 64'(bus.out_flit), 64'h0_2000_0003);
    set_in(2, TAIL, 32'h2000_0004, 1'b1);
    #1;
    check("bp_tail_ack", 64'(bus.in_ack), 64'h04);
    tick();
    check("bp_tail_out", 64'(bus.out_flit), 64'h1_2000_0004);
    check("bp_unlocked", 64'(bus.locked),   64'h0);
    clear_all();
    tick();
    check("bp_drained", 64'(bus.out_req), 64'h0);

    // Framing error: body flit offered while idle.
    set_in(2, BODY, 32'h1234_5678, 1'b1);
    #1;
    check("fe_in_ack", 64'(bus.in_ack), 64'h0);
    tick();
    check("fe_proto_err", 64'(bus.proto_err), 64'h1);
    check("fe_out_req",   64'(bus.out_req),   64'h0);
    set_in(2, HEAD, 32'hABCD_0001, 1'b1);
    #1;
    check("fe_head_ack", 64'(bus.in_ack), 64'h04);
    tick();
    check("fe_head_out",    64'(bus.out_flit),  64'h2_ABCD_0001);
    check("fe_locked",      64'(bus.locked),    64'h1);
    check("fe_owner",       64'(bus.owner),     64'h2);
    check("fe_err_sticky",  64'(bus.proto_err), 64'h1);

    // Asynchronous reset mid-packet, between clock edges.
    set_in(2, BODY, 32'hABCD_0002, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check("ar_out_req",   64'(bus.out_req),   64'h0);
    check("ar_locked",    64'(bus.locked),    64'h0);
    check("ar_owner",     64'(bus.owner),     64'h0);
    check("ar_proto_err", 64'(bus.proto_err), 64'h0);
    check("ar_out_flit",  64'(bus.out_flit),  64'h0);
    check("ar_in_ack",    64'(bus.in_ack),    64'h0);
    clear_all();
    tick();
    rst = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/router_out_arbiter.md
Name: router_out_arbiter

Overview:
- Wormhole output-port arbiter for one output of the 5-port mesh router.
- Shares one 34-bit output channel among NUM_IN input ports using round-robin.
- Locks the channel from a head flit through its tail flit, then re-arbitrates.
- Holds the outgoing flit in a single output register with req/ack flow control toward the downstream router.

Parameters:
- NUM_IN, 5, number of requesting input ports. Index 0 = local PE, 1-4 = mesh directions.
- FLIT_W, 34, flit width. Bits [33:32] = type: 2'b10 head, 2'b00 body, 2'b01 tail, 2'b11 single (head+tail). Bits [31:0] = payload.

Ports:
- clk, input, 1: the single clock; all state changes on posedge.
- rst, input, 1: asynchronous, active-low reset.
- in_flit, input, NUM_IN*FLIT_W: flit offered by input i on bits [i*FLIT_W +: FLIT_W]; already routed to this output.
- in_req, input, NUM_IN: input i offers a valid flit.
- in_ack, output, NUM_IN: one-hot, combinational; input i's flit is consumed this cycle.
- out_flit, output, FLIT_W: registered outgoing flit.
- out_req, output, 1: registered; out_flit is valid.
- out_ack, input, 1: downstream accepts out_flit this cycle when out_req=1.
- owner, output, 3: current locked input index; 0 when idle.
- locked, output, 1: channel held by a packet in flight.
- proto_err, output, 1: sticky; set on a framing violation; cleared only by reset.

Behaviour:
- Reset (rst=0, async): out_req=0, out_flit=0, locked=0, owner=0, rr_ptr=0, proto_err=0. in_ack=0 for as long as rst=0.
- load_en = !out_req || out_ack. The output register loads only when load_en=1.
- State IDLE (locked=0):
  - Eligible inputs are those with in_req[i]=1 and flit type head (10) or single (11).
  - The winner is the first eligible input at or after rr_ptr, wrapping at NUM_IN-1 to 0.
  - If load_en=1 and a winner g exists: in_ack[g]=1, out_flit<=in_flit[g], out_req<=1, rr_ptr<=(g+1) mod NUM_IN.
  - Head type: go to LOCKED with owner<=g. Single type: stay in IDLE.
- IDLE framing violation: an input offering body or tail type is never acked and sets proto_err<=1.
- State LOCKED (locked=1):
  - Only the owner is served. All other in_ack stay 0, regardless of their in_req.
  - If load_en=1 and in_req[owner]=1: ack owner and load the flit.
  - Tail type: go to IDLE, owner<=0, rr_ptr<=(owner+1) mod NUM_IN.
  - Body type: stay in LOCKED.
  - Head or single type from the owner: set proto_err<=1, do not ack, stay in LOCKED.
- Output drain: if out_req=1, out_ack=1 and nothing is accepted this cycle, then out_req<=0 and out_flit holds its value.
- Simultaneous drain and load: a new flit loads in the same cycle (out_req stays 1). This gives one flit per cycle throughput when downstream acks continuously.
- Latency: a flit accepted at edge N appears on out_flit after edge N.
- Stall: while out_req=1 and out_ack=0, out_flit is held stable, in_ack=0, and the arbiter state is frozen.
- in_ack has at most one bit set per cycle and never asserts unless the matching in_req=1.
- Reset mid-packet: the lock is dropped immediately and the partial packet is discarded. Upstream recovery is out of scope.

Test Plan:
- Reset, then in_req=5'b00001 with a single flit 34'h3_0000_00AA and out_ack=1. Required: in_ack=5'b00001 in that cycle; out_flit=34'h3_0000_00AA and out_req=1 next cycle; rr_ptr=1; locked stays 0.
- Inputs 1 and 3 each send a 3-flit packet (head, body, tail) with rr_ptr=0 and out_ack=1. Required: input 1's three flits go out back-to-back on consecutive cycles with in_ack[3]=0 throughout; then input 3's packet follows; rr_ptr ends at 4.
- Fairness: all 5 inputs continuously offer single flits. Required: grant order 0,1,2,3,4,0 and one flit per cycle.
- Backpressure: hold out_ack=0 for 4 cycles mid-packet. Required: out_flit stable, in_ack=0, owner unchanged. After out_ack=1, the stream resumes with no lost or duplicated flits.
- Framing error: in IDLE, input 2 offers body flit 34'h0_1234_5678. Required: in_ack=0 and proto_err=1 next cycle. A head flit from input 2 is then still granted normally.
- Async reset while locked=1 and out_req=1. Required: out_req, locked, owner and proto_err go to 0 without waiting for a clk edge.
